// File: rtl/infer_reader_pkg.sv
// Shared definitions for the post-halt inference read initiator.
package infer_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SK  = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_LAT = 3'd3,
    S_PRESENT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  // One register stage in the core plus the memory pipeline.
  localparam int CORE_MEM_LAT     = 3;
  localparam int DEFAULT_READ_LAT = 1 + CORE_MEM_LAT;

endpackage

// File: rtl/infer_reader_if.sv
// Valid/ready stream carrying captured words and their addresses.
interface infer_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );

endinterface

// File: rtl/infer_reader.sv
// Sweeps a word-address window through the core's inference read port once
// the core has halted, and streams each captured word to a consumer.
module infer_reader
  import infer_reader_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = DEFAULT_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              sk,
  output logic              infer,
  output logic [ADDR_W-1:0] infer_addr,
  input  logic [DATA_W-1:0] infer_data,
  infer_reader_if.master    out_if,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = $clog2(READ_LAT + 1);

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] cur_addr;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_addr  = out_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      remaining   <= '0;
      cur_addr    <= '0;
      infer       <= 1'b0;
      infer_addr  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= count;
            if (count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_WAIT_SK;
              done  <= 1'b0;
              busy  <= 1'b1;
            end
          end
        end

        // sk is a one-shot gate: once the core has halted it stays halted.
        S_WAIT_SK: begin
          if (sk) begin
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          infer      <= 1'b1;
          infer_addr <= cur_addr;
          lat_cnt    <= LAT_W'(READ_LAT - 1);
          state      <= S_WAIT_LAT;
        end

        // The core re-registers infer_addr every cycle infer is high, so the
        // address must not move until the word has been captured.
        S_WAIT_LAT: begin
          if (lat_cnt == '0) begin
            out_data_q  <= infer_data;
            out_addr_q  <= cur_addr;
            out_valid_q <= 1'b1;
            infer       <= 1'b0;
            state       <= S_PRESENT;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        S_PRESENT: begin
          if (out_valid_q && out_if.out_ready) begin
            out_valid_q <= 1'b0;
            remaining   <= remaining - ADDR_W'(1);
            cur_addr    <= cur_addr + ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_infer_reader.sv
// Scoreboard bench for infer_reader: a word-addressed memory model behind a
// fixed-latency read port, expected words queued per sweep and popped on handshake.
module tb_infer_reader;
  import infer_reader_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = DEFAULT_READ_LAT;
  localparam int BUDGET   = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              sk = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] count = '0;
  logic              infer;
  logic [ADDR_W-1:0] infer_addr;
  logic [DATA_W-1:0] infer_data;
  logic              busy;
  logic              done;

  infer_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  infer_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .sk         (sk),
    .infer      (infer),
    .infer_addr (infer_addr),
    .infer_data (infer_data),
    .out_if     (bus.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory contents: the test-plan words at 0x10..0x13, an address hash elsewhere.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    if (a >= 16'h0010 && a <= 16'h0013) return 32'h0000_00A0 + 32'(a - 16'h0010);
    return {a ^ 16'hC3C3, a + 16'h1111};
  endfunction

  // Read port: data for the address launched on one edge is readable READ_LAT cycles later.
  logic [DATA_W-1:0] rd_pipe [READ_LAT-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_val(infer_addr);
    for (int i = 1; i < READ_LAT - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign infer_data = rd_pipe[READ_LAT-2];

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } word_t;
  word_t exp_q [$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: scoreboard pops, hold-under-stall, latency and issue spacing.
  logic              prev_valid = 1'b0;
  logic              prev_ready = 1'b0;
  logic              prev_infer = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [ADDR_W-1:0] prev_addr = '0;
  int                infer_rise = 0;
  int                last_hs = 0;
  bit                hs_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_infer = 1'b0;
      hs_seen    = 1'b0;
    end else begin
      if (!busy) hs_seen = 1'b0;
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, prev_data);
        chk("hold_addr", bus.out_addr, prev_addr);
      end
      chk("infer_while_valid", infer & bus.out_valid, 1'b0);
      if (infer && !prev_infer) begin
        infer_rise = cyc;
        if (hs_seen) chk("issue_after_handshake", cyc - last_hs, 2);
      end
      if (bus.out_valid && !prev_valid) chk("read_latency", cyc - infer_rise, READ_LAT);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word got addr=%0h data=%0h expected no word", bus.out_addr, bus.out_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          chk("word_addr", bus.out_addr, w.a);
          chk("word_data", bus.out_data, w.d);
        end
        last_hs = cyc;
        hs_seen = 1'b1;
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_infer = infer;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_infer"}, infer, 1'b0);
    chk({tag, "_infer_addr"}, infer_addr, '0);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_out_data"}, bus.out_data, '0);
    chk({tag, "_out_addr"}, bus.out_addr, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 stall word index 2 for 7 cycles.
  task automatic sweep(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n,
                       input int sk_delay, input int rmode, input bit midstart);
    int words = 0;
    int stall = 0;
    int budget = 0;
    bit ms_done = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      word_t w;
      w.a = b + ADDR_W'(i);
      w.d = mem_val(w.a);
      exp_q.push_back(w);
    end
    base_addr     = b;
    count         = n;
    sk            = (sk_delay == 0);
    bus.out_ready = (rmode != 2);
    start         = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, n != 0);
    chk("done_after_start", done, n == 0);
    if (n == 0) begin
      for (int i = 0; i < 5; i++) begin
        chk("empty_no_infer", infer, 1'b0);
        chk("empty_done_level", done, 1'b1);
        tick();
      end
      return;
    end
    if (sk_delay > 0) begin
      for (int i = 0; i < sk_delay; i++) begin
        chk("infer_before_sk", infer, 1'b0);
        tick();
      end
      sk = 1'b1;
      tick();
      chk("infer_in_issue_cycle", infer, 1'b0);
      tick();
      chk("infer_after_sk", infer, 1'b1);
    end
    while (!done && budget < BUDGET) begin
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = !(words == 2 && stall < 7);
      endcase
      if (rmode == 2 && words == 2 && bus.out_valid && !bus.out_ready) stall++;
      if (midstart && words == 1 && !ms_done) begin
        start     = 1'b1;
        base_addr = b + 16'd100;
        count     = 16'd9;
        ms_done   = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) words++;
      tick();
      budget++;
    end
    start = 1'b0;
    chk("sweep_in_budget", budget < BUDGET, 1'b1);
    chk("done_at_end", done, 1'b1);
    chk("busy_at_end", busy, 1'b0);
    chk("words_accepted", words, n);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("infer_idle_at_end", infer, 1'b0);
    if (rmode == 2) chk("stall_cycles", stall, 7);
    tick();
  endtask

  initial begin
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic sweep over the preloaded window.
    sweep(16'h0010, 16'd4, 0, 0, 1'b0);
    // Core not yet halted for 20 cycles.
    sweep(16'h0020, 16'd3, 20, 0, 1'b0);
    // Backpressure on the third word.
    sweep(16'h0030, 16'd5, 0, 2, 1'b0);
    // Empty window, then address wrap.
    sweep(16'h0050, 16'd0, 0, 0, 1'b0);
    sweep(16'hFFFF, 16'd2, 0, 0, 1'b0);
    // start mid-sweep must be ignored.
    sweep(16'h0100, 16'd4, 0, 0, 1'b1);

    // Reset during WAIT_LAT discards the in-flight word.
    begin
      int k = 0;
      base_addr = 16'h0200;
      count     = 16'd3;
      sk        = 1'b1;
      bus.out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!infer && k < 20) begin
        tick();
        k++;
      end
      chk("infer_before_reset", infer, 1'b1);
      tick();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk_all_zero("after_reset");
    end
    sweep(16'h0300, 16'd3, 0, 0, 1'b0);

    // Randomized windows, halt delays and consumer backpressure.
    for (int r = 0; r < 8; r++) begin
      logic [ADDR_W-1:0] b;
      b = (r % 3 == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      sweep(b, 16'($urandom_range(1, 6)), ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0, 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
